// File: rtl/reg_read_resp_pkg.sv
// ---------------------------------------------------------------------------
// reg_read_resp_pkg
//
// Shared definitions for the register read/response block:
//   - default geometry (data width, register count, address width)
//   - response counter width and type
//   - FSM state encoding used by reg_read_resp
// ---------------------------------------------------------------------------
package reg_read_resp_pkg;

  // Default geometry of the register bank.
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

  // Completed-response counter; wraps naturally at 2**CNT_W.
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] count_t;

  // FSM state encoding. Kept as plain constants so the encoding is fixed
  // and visible to anything that probes the state register.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  // True when n is a non-zero power of two (geometry sanity helper).
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage : reg_read_resp_pkg

// File: rtl/reg_read_resp_bank.sv
// ---------------------------------------------------------------------------
// reg_bank
//
// DEPTH x DATA_W register storage with one synchronous write port and one
// combinational read port. The read port bypasses a same-cycle write to the
// same index, so the read value equals the register contents as they will be
// after the coming rising edge.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, clears every register
//   wr_en    in   write strobe
//   wr_addr  in   write register index
//   wr_data  in   write value
//   rd_addr  in   read register index
//   rd_data  out  combinational read value (with write bypass)
// ---------------------------------------------------------------------------
module reg_bank
  import reg_read_resp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Flattened view of all registers for the read mux.
  logic [DATA_W-1:0] regs_w [DEPTH];

  // The bank needs a reset to zero, so each entry is a plain flop register
  // rather than an inferred RAM.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q;
      logic              hit;

      assign hit = wr_en && (wr_addr == ADDR_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          reg_q <= '0;
        end else if (hit) begin
          reg_q <= wr_data;
        end
      end

      assign regs_w[gi] = reg_q;
    end
  endgenerate

  // Write bypass: a read of the index being written this cycle returns the
  // new value, matching what the register will hold after the edge.
  always_comb begin
    rd_data = regs_w[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule : reg_bank

// File: rtl/reg_read_resp.sv
// ---------------------------------------------------------------------------
// reg_read_resp
//
// Register bank with a single-outstanding read request/response channel.
// A request is granted combinationally when no response is pending, or when
// the pending response is being accepted in the same cycle (back-to-back
// reads, one response per cycle). The response is a snapshot taken at the
// grant edge and stays stable while the consumer stalls.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   wr_en     in   write strobe
//   wr_addr   in   write register index
//   wr_data   in   write value
//   rd_req    in   read request valid
//   rd_addr   in   read register index, valid with rd_req
//   rd_gnt    out  request accepted this cycle (combinational)
//   rd_valid  out  response data valid
//   rd_ready  in   consumer accepts the response
//   rd_data   out  response value
//   rd_count  out  completed responses, modulo 256
//
// ADDR_W must equal log2(DEPTH) and DEPTH must be a power of two >= 2.
// ---------------------------------------------------------------------------
module reg_read_resp
  import reg_read_resp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  rd_count
);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  count_t            count_q, count_d;

  logic [DATA_W-1:0] bank_rd_data;
  logic              complete;

  // Storage with write bypass on the read port.
  reg_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (bank_rd_data)
  );

  // A response is outstanding exactly while in RESP.
  assign rd_valid = (state_q == ST_RESP);
  assign complete = rd_valid && rd_ready;

  // Grant when the channel is free now or frees up at this edge. Reset
  // masks the grant so nothing is accepted while the block is clearing.
  assign rd_gnt = !rst && rd_req && ((state_q == ST_IDLE) || complete);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;

    if (complete) begin
      count_d = count_q + count_t'(1);
    end

    if (rd_gnt) begin
      // Snapshot the (bypassed) register value; it is held until the
      // consumer accepts it, regardless of later writes.
      state_d = ST_RESP;
      data_d  = bank_rd_data;
    end else if (complete) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign rd_data  = data_q;
  assign rd_count = count_q;

endmodule : reg_read_resp

// File: tb/tb_reg_read_resp.sv
// ---------------------------------------------------------------------------
// tb_reg_read_resp
//
// Stimulus task drives one cycle of inputs, checks the grant and counter
// against a transaction-level model, then advances the model (register
// array, "response outstanding" flag, completed-read tally) and pushes the
// expected response value into a queue. An independent monitor on the
// falling edge compares rd_valid / rd_data against the queue head and pops
// on each accepted response.
// ---------------------------------------------------------------------------
module tb_reg_read_resp;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [7:0]    rd_count;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW-1:0] model_regs [DP];
  bit            model_busy;
  int            model_done;
  logic [DW-1:0] exp_q [$];
  bit            mon_en = 1'b0;

  always #5 clk = ~clk;

  reg_read_resp #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .ADDR_W (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_count (rd_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus. Entered and left at posedge+1.
  task automatic step(input bit r, input bit we, input int wa, input int wd,
                      input bit rq, input int ra, input bit rdy, output bit gnt);
    bit done;
    bit exp_gnt;
    rst      = r;
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = DW'(wd);
    rd_req   = rq;
    rd_addr  = AW'(ra);
    rd_ready = rdy;
    #2;
    done    = model_busy && rdy && !r;
    exp_gnt = !r && rq && (!model_busy || done);
    check("gnt", {31'd0, rd_gnt}, {31'd0, exp_gnt});
    check("count", {24'd0, rd_count}, 32'(model_done % 256));
    @(posedge clk);
    #1;
    if (r) begin
      foreach (model_regs[i]) model_regs[i] = '0;
      model_busy = 1'b0;
      model_done = 0;
      exp_q.delete();
    end else begin
      if (we) model_regs[wa] = DW'(wd);
      if (done) model_done++;
      if (exp_gnt) begin
        exp_q.push_back(model_regs[ra]);
        model_busy = 1'b1;
      end else if (done) begin
        model_busy = 1'b0;
      end
    end
    gnt = exp_gnt;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", {31'd0, rd_valid}, {31'd0, (exp_q.size() != 0)});
      if (rd_valid && exp_q.size() != 0) begin
        check("data", {24'd0, rd_data}, {24'd0, exp_q[0]});
        if (rd_ready && !rst) begin
          $display("resp data=%02h exp=%02h count_before=%0d", rd_data, exp_q[0], rd_count);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit g;
    bit held;
    int haddr;
    int c0;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_ready = 1'b0;
    foreach (model_regs[i]) model_regs[i] = '0;
    model_busy = 1'b0;
    model_done = 0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset with a request present: no grant.
    step(1, 0, 0, 0, 1, 0, 0, g);

    // Write AA to addr 1, then read it back.
    step(0, 1, 1, 'hAA, 0, 0, 1, g);
    step(0, 0, 0, 0, 1, 1, 1, g);
    check("req039_data", {24'd0, rd_data}, 32'hAA);
    step(0, 0, 0, 0, 0, 0, 1, g);
    check("req039_count", {24'd0, rd_count}, 32'd1);

    // Same-cycle write/read bypass.
    step(0, 1, 2, 'h55, 1, 2, 1, g);
    check("req040_data", {24'd0, rd_data}, 32'h55);
    step(0, 0, 0, 0, 0, 0, 1, g);

    // Stalled response: snapshot holds while addr 3 is rewritten.
    step(0, 1, 3, 'h33, 0, 0, 0, g);
    step(0, 0, 0, 0, 1, 3, 0, g);
    for (int i = 0; i < 3; i++) step(0, 1, 3, 'h0F, 1, 3, 0, g);
    check("req041_data", {24'd0, rd_data}, 32'h33);
    step(0, 0, 0, 0, 1, 3, 1, g);
    check("req041_new", {24'd0, rd_data}, 32'h0F);
    step(0, 0, 0, 0, 0, 0, 1, g);

    // Back-to-back reads over all addresses.
    c0 = model_done;
    for (int a = 0; a < 4; a++) step(0, 0, 0, 0, 1, a, 1, g);
    step(0, 0, 0, 0, 0, 0, 1, g);
    check("req042_count", {24'd0, rd_count}, 32'((c0 + 4) % 256));

    // Counter wrap: 300 completions from reset.
    step(1, 0, 0, 0, 0, 0, 0, g);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 1, i % 4, 1, g);
    step(0, 0, 0, 0, 0, 0, 1, g);
    check("req043_count", {24'd0, rd_count}, 32'd44);

    // Reset while a response is pending (with a competing write).
    for (int a = 0; a < 4; a++) step(0, 1, a, 'h70 + a, 0, 0, 0, g);
    step(0, 0, 0, 0, 1, 2, 0, g);
    step(1, 1, 1, 'h99, 0, 0, 1, g);
    check("req044_valid", {31'd0, rd_valid}, 32'd0);
    check("req044_count", {24'd0, rd_count}, 32'd0);
    for (int a = 0; a < 4; a++) step(0, 0, 0, 0, 1, a, 1, g);
    step(0, 0, 0, 0, 0, 0, 1, g);

    // Randomized traffic; an ungranted request is held with its address.
    held = 1'b0;
    haddr = 0;
    for (int i = 0; i < 500; i++) begin
      bit r, we, rq, rdy;
      int wa, wd, ra;
      r   = ($urandom_range(0, 63) == 0);
      we  = 1'($urandom_range(0, 1));
      wa  = int'($urandom_range(0, 3));
      wd  = int'($urandom_range(0, 255));
      rdy = ($urandom_range(0, 3) != 0);
      if (held) begin
        rq = 1'b1;
        ra = haddr;
      end else begin
        rq = 1'($urandom_range(0, 1));
        ra = int'($urandom_range(0, 3));
      end
      step(r, we, wa, wd, rq, ra, rdy, g);
      held  = rq && !g && !r;
      haddr = ra;
    end

    // Drain.
    step(0, 0, 0, 0, 0, 0, 1, g);
    step(0, 0, 0, 0, 0, 0, 1, g);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_read_resp
